ss_engine: RTL and testbench

//  Save-state sequencer that drives the mapper save-state port (ss_act, ss_we, ss_addr,

---
 rtl/ss_engine.sv | 206 ++++++++++++++++++++
 tb/tb_ss_engine.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ss_engine.sv
// Save-state sequencer: SAVE copies mapper state bytes into an external buffer,
// LOAD replays the buffer into the mapper, each write held across one m2 fall.
module ss_engine #(
  parameter int SS_LEN     = 256,
  parameter int SETTLE     = 2,
  parameter int M2_TIMEOUT = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_save,
  input  logic       cmd_load,
  input  logic       m2,
  input  logic [7:0] ss_rdat,
  input  logic [7:0] buf_rdat,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       ss_act,
  output logic       ss_we,
  output logic [7:0] ss_addr,
  output logic [7:0] ss_wdat,
  output logic [7:0] buf_addr,
  output logic [7:0] buf_wdat,
  output logic       buf_we,
  output logic       buf_re
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int TW = (M2_TIMEOUT > 1) ? $clog2(M2_TIMEOUT) : 1;
  localparam logic [8:0]    LAST_IDX   = 9'(SS_LEN - 1);
  localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE - 1);
  localparam logic [TW-1:0] TMO_MAX    = TW'(M2_TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, S_ADDR, S_WAIT, S_CAPT, L_READ, L_LAT, L_WAITM2, L_HOLD, FIN
  } state_t;

  state_t        state_q, state_d;
  logic [8:0]    idx_q, idx_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          m2_meta_q, m2_sync_q, m2_prev_q;
  logic          busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic          act_q, act_d, we_q, we_d;
  logic [7:0]    ss_addr_q, ss_addr_d, ss_wdat_q, ss_wdat_d;
  logic [7:0]    buf_addr_q, buf_addr_d, buf_wdat_q, buf_wdat_d;
  logic          buf_we_q, buf_we_d, buf_re_q, buf_re_d;
  logic          m2_fall;
  logic [8:0]    idx_inc;

  assign m2_fall = m2_prev_q & ~m2_sync_q;
  assign idx_inc = idx_q + 9'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      settle_q   <= '0;
      tmo_q      <= '0;
      m2_meta_q  <= 1'b0;
      m2_sync_q  <= 1'b0;
      m2_prev_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      act_q      <= 1'b0;
      we_q       <= 1'b0;
      ss_addr_q  <= '0;
      ss_wdat_q  <= '0;
      buf_addr_q <= '0;
      buf_wdat_q <= '0;
      buf_we_q   <= 1'b0;
      buf_re_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      settle_q   <= settle_d;
      tmo_q      <= tmo_d;
      m2_meta_q  <= m2;
      m2_sync_q  <= m2_meta_q;
      m2_prev_q  <= m2_sync_q;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      act_q      <= act_d;
      we_q       <= we_d;
      ss_addr_q  <= ss_addr_d;
      ss_wdat_q  <= ss_wdat_d;
      buf_addr_q <= buf_addr_d;
      buf_wdat_q <= buf_wdat_d;
      buf_we_q   <= buf_we_d;
      buf_re_q   <= buf_re_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    settle_d   = settle_q;
    tmo_d      = tmo_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    act_d      = act_q;
    we_d       = we_q;
    ss_addr_d  = ss_addr_q;
    ss_wdat_d  = ss_wdat_q;
    buf_addr_d = buf_addr_q;
    buf_wdat_d = buf_wdat_q;
    buf_we_d   = 1'b0;
    buf_re_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_save || cmd_load) begin
          err_d  = 1'b0;
          busy_d = 1'b1;
          act_d  = 1'b1;
          idx_d  = '0;
          // The buffer read is launched on entry to L_READ so its data is
          // ready for L_LAT one cycle later.
          if (cmd_save) begin
            state_d = S_ADDR;
          end else begin
            state_d    = L_READ;
            buf_addr_d = '0;
            buf_re_d   = 1'b1;
          end
        end
      end
      S_ADDR: begin
        ss_addr_d = idx_q[7:0];
        settle_d  = '0;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        if (settle_q == SETTLE_MAX) state_d = S_CAPT;
        else                        settle_d = settle_q + 1'b1;
      end
      S_CAPT: begin
        buf_addr_d = idx_q[7:0];
        buf_wdat_d = ss_rdat;
        buf_we_d   = 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = FIN;
        end else begin
          idx_d   = idx_inc;
          state_d = S_ADDR;
        end
      end
      L_READ: state_d = L_LAT;
      L_LAT: begin
        ss_wdat_d = buf_rdat;
        ss_addr_d = idx_q[7:0];
        we_d      = 1'b1;
        tmo_d     = '0;
        state_d   = L_WAITM2;
      end
      L_WAITM2: begin
        if (m2_fall) begin
          state_d = L_HOLD;
        end else if (tmo_q == TMO_MAX) begin
          we_d    = 1'b0;
          err_d   = 1'b1;
          state_d = FIN;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      L_HOLD: begin
        we_d = 1'b0;
        if (idx_q == LAST_IDX) begin
          state_d = FIN;
        end else begin
          idx_d      = idx_inc;
          buf_addr_d = idx_inc[7:0];
          buf_re_d   = 1'b1;
          state_d    = L_READ;
        end
      end
      FIN: begin
        act_d      = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b1;
        ss_addr_d  = '0;
        ss_wdat_d  = '0;
        buf_addr_d = '0;
        buf_wdat_d = '0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign ss_act   = act_q;
  assign ss_we    = we_q;
  assign ss_addr  = ss_addr_q;
  assign ss_wdat  = ss_wdat_q;
  assign buf_addr = buf_addr_q;
  assign buf_wdat = buf_wdat_q;
  assign buf_we   = buf_we_q;
  assign buf_re   = buf_re_q;

endmodule

// File: tb/tb_ss_engine.sv
// Scoreboard bench for ss_engine: a 256-byte instance and a 1-byte instance
// sharing clock, reset and an asynchronous m2.
module tb_ss_engine;

  logic       clk, rst, m2, m2_run;
  logic       cmd_save, cmd_load, cmd_save1, cmd_load1;
  logic [7:0] ss_rdat, buf_rdat, ss_rdat1, buf_rdat1;
  logic       busy, done, err, ss_act, ss_we, buf_we, buf_re;
  logic [7:0] ss_addr, ss_wdat, buf_addr, buf_wdat;
  logic       busy1, done1, err1, ss_act1, ss_we1, buf_we1, buf_re1;
  logic [7:0] ss_addr1, ss_wdat1, buf_addr1, buf_wdat1;

  ss_engine #(.SS_LEN(256), .SETTLE(2), .M2_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .cmd_save(cmd_save), .cmd_load(cmd_load), .m2(m2),
    .ss_rdat(ss_rdat), .buf_rdat(buf_rdat), .busy(busy), .done(done), .err(err),
    .ss_act(ss_act), .ss_we(ss_we), .ss_addr(ss_addr), .ss_wdat(ss_wdat),
    .buf_addr(buf_addr), .buf_wdat(buf_wdat), .buf_we(buf_we), .buf_re(buf_re)
  );

  ss_engine #(.SS_LEN(1), .SETTLE(2), .M2_TIMEOUT(16)) dut1 (
    .clk(clk), .rst(rst), .cmd_save(cmd_save1), .cmd_load(cmd_load1), .m2(m2),
    .ss_rdat(ss_rdat1), .buf_rdat(buf_rdat1), .busy(busy1), .done(done1), .err(err1),
    .ss_act(ss_act1), .ss_we(ss_we1), .ss_addr(ss_addr1), .ss_wdat(ss_wdat1),
    .buf_addr(buf_addr1), .buf_wdat(buf_wdat1), .buf_we(buf_we1), .buf_re(buf_re1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // m2 period is 12 clk periods, phase-offset from clk; stuck low when disabled.
  initial begin
    m2 = 1'b0;
    #3;
    forever begin
      #60;
      m2 = m2_run ? ~m2 : 1'b0;
    end
  end

  assign ss_rdat  = ~ss_addr;
  assign ss_rdat1 = ~ss_addr1;

  logic [7:0] mem  [256];
  logic [7:0] mem1 [256];
  logic       preload_req;

  always @(posedge clk) begin
    if (preload_req) for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
    else if (buf_we) mem[buf_addr] <= buf_wdat;
    if (buf_re) buf_rdat <= mem[buf_addr];
  end

  always @(posedge clk) begin
    if (buf_we1) mem1[buf_addr1] <= buf_wdat1;
    if (buf_re1) buf_rdat1 <= mem1[buf_addr1];
  end

  // Scoreboard entries are {address, data}.
  logic [15:0] exp_q[$];
  int bwe_cnt, bre_cnt, done_cnt, win_cnt, we_hi;
  int falls_total = 0, win_start = 0;
  logic chk_falls, prev_we;
  logic [7:0] win_addr, win_data;

  always @(negedge m2) if (ss_we) falls_total++;
  always @(posedge ss_we) win_start = falls_total;

  always @(negedge clk) begin
    logic [15:0] e;
    if (rst) begin
      prev_we = 1'b0;
    end else begin
      if (buf_we) begin
        bwe_cnt++;
        if (exp_q.size() == 0) check("sv_extra", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("sv_addr", buf_addr, e[15:8]);
          check("sv_data", buf_wdat, e[7:0]);
        end
      end
      if (buf_re) bre_cnt++;
      if (done) done_cnt++;
      if (ss_we) we_hi++;
      if (ss_we && !prev_we) begin
        win_cnt++;
        if (exp_q.size() == 0) begin
          check("ld_extra", 1, 0);
          win_addr = ss_addr;
          win_data = ss_wdat;
        end else begin
          e = exp_q.pop_front();
          win_addr = e[15:8];
          win_data = e[7:0];
          check("ld_addr", ss_addr, win_addr);
          check("ld_data", ss_wdat, win_data);
        end
      end else if (ss_we && prev_we) begin
        check("ld_stable", {ss_addr, ss_wdat}, {win_addr, win_data});
      end
      if (!ss_we && prev_we && chk_falls) check("ld_m2falls", falls_total - win_start, 1);
      prev_we = ss_we;
    end
  end

  int bwe1_cnt, win1_cnt;
  logic [7:0] cap_baddr1, cap_bdat1, cap_saddr1, cap_sdat1;
  logic prev_we1;

  always @(negedge clk) begin
    if (rst) begin
      prev_we1 = 1'b0;
    end else begin
      if (buf_we1) begin
        bwe1_cnt++;
        cap_baddr1 = buf_addr1;
        cap_bdat1  = buf_wdat1;
      end
      if (ss_we1 && !prev_we1) begin
        win1_cnt++;
        cap_saddr1 = ss_addr1;
        cap_sdat1  = ss_wdat1;
      end
      prev_we1 = ss_we1;
    end
  end

  task automatic clear_counts();
    bwe_cnt = 0; bre_cnt = 0; done_cnt = 0; win_cnt = 0; we_hi = 0;
  endtask

  task automatic issue(input logic sel, input logic s, input logic l);
    @(posedge clk); #1;
    if (sel) begin cmd_save1 = s; cmd_load1 = l; end
    else     begin cmd_save  = s; cmd_load  = l; end
    @(posedge clk); #1;
    cmd_save = 0; cmd_load = 0; cmd_save1 = 0; cmd_load1 = 0;
  endtask

  task automatic wait_done(input logic sel, input int budget, output int n);
    logic got;
    got = 0;
    n = 0;
    while (!got && n < budget) begin
      @(posedge clk); n++; #1;
      if (sel ? done1 : done) got = 1;
    end
    if (!got) check("done_timeout", 0, 1);
  endtask

  task automatic push_save(input int len);
    for (int i = 0; i < len; i++) exp_q.push_back({8'(i), ~8'(i)});
  endtask

  task automatic push_load(input int len);
    for (int i = 0; i < len; i++) exp_q.push_back({8'(i), 8'(i) ^ 8'h5A});
  endtask

  task automatic preload();
    @(posedge clk); #1 preload_req = 1;
    @(posedge clk); #1 preload_req = 0;
  endtask

  initial begin
    int n;
    logic found;
    rst = 1; m2_run = 1; chk_falls = 1; preload_req = 0; prev_we = 0; prev_we1 = 0;
    cmd_save = 0; cmd_load = 0; cmd_save1 = 0; cmd_load1 = 0;
    bwe1_cnt = 0; win1_cnt = 0;
    clear_counts();
    repeat (3) @(negedge clk);
    check("reset_outs", {busy, done, err, ss_act, ss_we, buf_we, buf_re, ss_addr, ss_wdat, buf_addr, buf_wdat}, 0);
    check("reset_outs1", {busy1, done1, err1, ss_act1, ss_we1, buf_we1, buf_re1, ss_addr1}, 0);
    #2 rst = 0;

    // Plain SAVE of 256 bytes with ss_rdat = ~ss_addr.
    clear_counts();
    push_save(256);
    issue(0, 1, 0);
    check("save_busy", {busy, ss_act}, 2'b11);
    wait_done(0, 1100, n);
    check("save_latency", n, 1025);
    check("save_fin_outs", {busy, ss_act, ss_addr}, 0);
    repeat (2) @(posedge clk);
    check("save_bwe_cnt", bwe_cnt, 256);
    check("save_buf0", mem[0], 8'hFF);
    check("save_buf127", mem[127], 8'h80);
    check("save_err", err, 0);
    check("save_no_ld", win_cnt, 0);
    check("save_done_cnt", done_cnt, 1);
    check("save_q_empty", exp_q.size(), 0);
    $display("op save len=256 latency=%0d err=%0b", n, err);

    // LOAD of addr^5A with m2 running.
    preload();
    clear_counts();
    push_load(256);
    @(posedge m2);
    issue(0, 0, 1);
    wait_done(0, 256 * 20 + 100, n);
    repeat (2) @(posedge clk);
    check("load_windows", win_cnt, 256);
    check("load_err", err, 0);
    check("load_done_cnt", done_cnt, 1);
    check("load_idle", {busy, ss_act, ss_we, ss_addr, ss_wdat}, 0);
    check("load_q_empty", exp_q.size(), 0);
    $display("op load len=256 cycles=%0d err=%0b", n, err);

    // LOAD with m2 stuck low times out on the first byte.
    m2_run = 0;
    repeat (20) @(posedge clk);
    clear_counts();
    chk_falls = 0;
    push_load(1);
    issue(0, 0, 1);
    wait_done(0, 100, n);
    check("tmo_err", err, 1);
    check("tmo_act", ss_act, 0);
    repeat (2) @(posedge clk);
    check("tmo_we_cycles", we_hi, 16);
    check("tmo_done_cnt", done_cnt, 1);
    check("tmo_err_sticky", err, 1);
    chk_falls = 1;
    $display("op load timeout cycles=%0d err=%0b", n, err);

    clear_counts();
    push_save(256);
    issue(0, 1, 0);
    check("tmo_err_clear", {err, busy}, 2'b01);
    wait_done(0, 1100, n);
    check("tmo_save_latency", n, 1025);
    $display("op save after timeout latency=%0d err=%0b", n, err);

    // Simultaneous commands: SAVE wins; later cmd_load pulses are ignored.
    repeat (2) @(posedge clk);
    clear_counts();
    push_save(256);
    issue(0, 1, 1);
    for (int k = 0; k < 4; k++) begin
      repeat (50) @(posedge clk);
      #1 cmd_load = 1;
      @(posedge clk); #1 cmd_load = 0;
    end
    wait_done(0, 1100, n);
    repeat (10) @(posedge clk);
    check("both_bwe_cnt", bwe_cnt, 256);
    check("both_no_bre", bre_cnt, 0);
    check("both_no_ld", win_cnt, 0);
    check("both_done_cnt", done_cnt, 1);
    check("both_idle", busy, 0);
    $display("op save+load same cycle done, bwe=%0d bre=%0d", bwe_cnt, bre_cnt);

    // Asynchronous reset in the middle of a LOAD, at index 40.
    m2_run = 1;
    preload();
    clear_counts();
    push_load(256);
    @(posedge m2);
    issue(0, 0, 1);
    found = 0;
    for (int k = 0; k < 2000 && !found; k++) begin
      @(negedge clk);
      if (ss_we && ss_addr == 8'd40) found = 1;
    end
    check("rst_reached40", found, 1);
    #2 rst = 1;
    #1 check("rst_async", {ss_act, ss_we, busy}, 0);
    repeat (3) @(posedge clk);
    exp_q.delete();
    @(negedge clk) rst = 0;
    repeat (5) @(posedge clk);
    #1 check("rst_idle", {busy, ss_act, ss_we, err}, 0);
    check("rst_no_done", done_cnt, 0);
    $display("op load aborted by reset at index 40");

    // SS_LEN = 1 instance: one buffer write, one mapper write window.
    issue(1, 1, 0);
    wait_done(1, 50, n);
    check("len1_save_latency", n, 5);
    repeat (2) @(posedge clk);
    check("len1_bwe_cnt", bwe1_cnt, 1);
    check("len1_bwe", {cap_baddr1, cap_bdat1}, 16'h00FF);
    @(posedge m2);
    issue(1, 0, 1);
    wait_done(1, 100, n);
    repeat (2) @(posedge clk);
    check("len1_windows", win1_cnt, 1);
    check("len1_ld", {cap_saddr1, cap_sdat1}, 16'h00FF);
    check("len1_idle", {busy1, ss_act1, ss_we1, err1}, 0);
    $display("op len1 save/load done, bwe=%0d windows=%0d", bwe1_cnt, win1_cnt);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
